// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 16-bit synchronous RAM.
// Round-robin between fetch and data ports; byte stores are done as read-modify-write.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    output logic [15:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic        data_byte_half,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ack,
    output logic [15:0] data_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdData,
        StWr,
        StRmwIssue,
        StRmwWrite
    } state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;     // 1 = data port owns the access
    logic        last_q, last_d;     // 1 = data port granted last
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        half_q, half_d;
    logic [15:0] wdata_q, wdata_d;
    logic        fetch_ack_q, fetch_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [15:0] fetch_rdata_q, fetch_rdata_d;
    logic [15:0] data_rdata_q, data_rdata_d;

    logic        fetch_elig, data_elig, grant_data;
    logic [15:0] rd_word;
    logic        ram_en_dec, ram_we_dec;

    // A requester whose ack is high this cycle is still holding the finished request.
    assign fetch_elig = fetch_req & ~fetch_ack_q;
    assign data_elig  = data_req & ~data_ack_q;
    assign grant_data = data_elig & (~fetch_elig | ~last_q);

    assign rd_word = half_q ? ram_rdata
                   : {8'b0, (addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0])};

    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        last_d        = last_q;
        addr_d        = addr_q;
        we_d          = we_q;
        half_d        = half_q;
        wdata_d       = wdata_q;
        fetch_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        fetch_rdata_d = fetch_rdata_q;
        data_rdata_d  = data_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_elig || data_elig) begin
                    port_d = grant_data;
                    last_d = grant_data;
                    if (grant_data) begin
                        addr_d  = data_addr;
                        we_d    = data_we;
                        half_d  = data_byte_half;
                        wdata_d = data_wdata;
                    end else begin
                        addr_d  = fetch_addr;
                        we_d    = 1'b0;
                        half_d  = 1'b1;
                        wdata_d = 16'h0000;
                    end
                    if (!we_d)       state_d = StRdIssue;
                    else if (half_d) state_d = StWr;
                    else             state_d = StRmwIssue;
                end
            end
            StRdIssue:  state_d = StRdData;
            StRdData: begin
                if (port_q) begin
                    data_rdata_d = rd_word;
                    data_ack_d   = 1'b1;
                end else begin
                    fetch_rdata_d = rd_word;
                    fetch_ack_d   = 1'b1;
                end
                state_d = StIdle;
            end
            StWr, StRmwWrite: begin
                data_ack_d  = port_q;
                fetch_ack_d = ~port_q;
                state_d     = StIdle;
            end
            StRmwIssue: state_d = StRmwWrite;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_en_dec = 1'b0;
        ram_we_dec = 1'b0;
        ram_wdata  = 16'h0000;
        ram_addr   = (state_q == StIdle) ? 15'h0000 : addr_q[15:1];
        unique case (state_q)
            StRdIssue, StRmwIssue: ram_en_dec = 1'b1;
            StWr: begin
                ram_en_dec = 1'b1;
                ram_we_dec = 1'b1;
                ram_wdata  = wdata_q;
            end
            StRmwWrite: begin
                ram_en_dec = 1'b1;
                ram_we_dec = 1'b1;
                ram_wdata  = addr_q[0] ? {wdata_q[7:0], ram_rdata[7:0]}
                                       : {ram_rdata[15:8], wdata_q[7:0]};
            end
            default: ;
        endcase
    end

    // Gating with reset keeps an in-flight write from landing in the RAM.
    assign ram_en = ram_en_dec & ~reset;
    assign ram_we = ram_we_dec & ~reset;
    assign busy   = (state_q != StIdle);

    assign fetch_ack   = fetch_ack_q;
    assign data_ack    = data_ack_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            port_q        <= 1'b0;
            last_q        <= 1'b1;
            addr_q        <= 16'h0000;
            we_q          <= 1'b0;
            half_q        <= 1'b0;
            wdata_q       <= 16'h0000;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            fetch_rdata_q <= 16'h0000;
            data_rdata_q  <= 16'h0000;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            half_q        <= half_d;
            wdata_q       <= wdata_d;
            fetch_ack_q   <= fetch_ack_d;
            data_ack_q    <= data_ack_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand sequences for timing corners plus a vector table
// of data-port transactions against a simple synchronous RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'h0;
    logic        fetch_ack;
    logic [15:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic        data_byte_half = 1'b1;
    logic [15:0] data_addr = 16'h0;
    logic [15:0] data_wdata = 16'h0;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_rdata   (fetch_rdata),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_byte_half(data_byte_half),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_ack      (data_ack),
        .data_rdata    (data_rdata),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // RAM model with a backdoor write port used while the arbiter is idle.
    logic [15:0] mem [0:32767];
    logic        bd_we = 1'b0;
    logic [14:0] bd_addr = 15'h0;
    logic [15:0] bd_data = 16'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one access on one port, returning cycles from grant cycle to ack (10 = timeout).
    task automatic xact(input logic is_fetch, input logic we, input logic half,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] rd);
        lat = 0;
        if (is_fetch) begin
            fetch_req  = 1'b1;
            fetch_addr = addr;
        end else begin
            data_req       = 1'b1;
            data_we        = we;
            data_byte_half = half;
            data_addr      = addr;
            data_wdata     = wdata;
        end
        while (lat < 10) begin
            tick();
            lat++;
            if (is_fetch ? fetch_ack : data_ack) break;
        end
        rd        = is_fetch ? fetch_rdata : data_rdata;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic        half;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fa_vec, da_vec, busy_vec, rd;
        int lat;

        vecs[0] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'hBEEF, 3};
        vecs[1] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h00EF, 3};
        vecs[2] = '{1'b0, 1'b0, 16'h0021, 16'h0000, 16'h00BE, 3};
        vecs[3] = '{1'b1, 1'b0, 16'h0021, 16'h55AB, 16'h0000, 3};
        vecs[4] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'hABEF, 3};
        vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h77CD, 16'h0000, 3};
        vecs[6] = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'hABCD, 3};
        vecs[7] = '{1'b1, 1'b1, 16'h0050, 16'h1357, 16'h0000, 2};
        vecs[8] = '{1'b0, 1'b0, 16'h0051, 16'h0000, 16'h0013, 3};
        vecs[9] = '{1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0057, 3};

        // Preload during reset.
        poke(15'h0000, 16'h0F0F);
        poke(15'h0010, 16'h2222);
        tick();
        reset = 1'b0;

        check("rst_fetch_ack", fetch_ack, 0);
        check("rst_data_ack", data_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_fetch_rdata", fetch_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);

        // Simultaneous requests straight out of reset, held to observe alternation.
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        data_req = 1'b1; data_we = 1'b0; data_byte_half = 1'b1; data_addr = 16'h0020;
        fa_vec = '0; da_vec = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            fa_vec[c] = fetch_ack;
            da_vec[c] = data_ack;
        end
        fetch_req = 1'b0; data_req = 1'b0;
        check("rr_fetch_acks", fa_vec, 16'h0208);
        check("rr_data_acks", da_vec, 16'h1040);
        check("rr_no_dual_ack", fa_vec & da_vec, 16'h0000);
        check("rr_fetch_rdata", fetch_rdata, 16'h0F0F);
        check("rr_data_rdata", data_rdata, 16'h2222);
        tick();
        check("rr_idle_after", busy, 0);

        // Word read timing.
        poke(15'h0010, 16'hBEEF);
        data_req = 1'b1; data_we = 1'b0; data_byte_half = 1'b1; data_addr = 16'h0020;
        tick();
        check("rd_c1_ram_en", ram_en, 1);
        check("rd_c1_ram_we", ram_we, 0);
        check("rd_c1_ram_addr", ram_addr, 15'h010);
        tick();
        check("rd_c2_no_ack", data_ack, 0);
        tick();
        check("rd_c3_ack", data_ack, 1);
        check("rd_c3_rdata", data_rdata, 16'hBEEF);
        data_req = 1'b0;
        tick();
        check("rd_c4_single_ack", data_ack, 0);

        // Byte store to lane 1 as read-modify-write.
        poke(15'h0010, 16'h1234);
        data_req = 1'b1; data_we = 1'b1; data_byte_half = 1'b0;
        data_addr = 16'h0021; data_wdata = 16'h00AB;
        tick();
        check("rmw_c1_read", {ram_en, ram_we}, 2'b10);
        tick();
        check("rmw_c2_write", {ram_en, ram_we}, 2'b11);
        check("rmw_c2_wdata", ram_wdata, 16'hAB34);
        tick();
        check("rmw_c3_ack", data_ack, 1);
        data_req = 1'b0;
        tick();
        xact(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, lat, rd);
        check("rmw_readback", rd, 16'h00AB);

        // Word store, then fetch with bit 0 set.
        data_req = 1'b1; data_we = 1'b1; data_byte_half = 1'b1;
        data_addr = 16'h0040; data_wdata = 16'h5A5A;
        tick();
        check("wr_c1_we", {ram_en, ram_we}, 2'b11);
        check("wr_c1_addr", ram_addr, 15'h020);
        tick();
        check("wr_c2_ack", data_ack, 1);
        check("wr_c2_we_off", ram_we, 0);
        data_req = 1'b0;
        tick();
        xact(1'b1, 1'b0, 1'b1, 16'h0041, 16'h0000, lat, rd);
        check("wr_fetch_lat", lat, 3);
        check("wr_fetch_data", rd, 16'h5A5A);

        // Reset during the write half of a byte store.
        poke(15'h0030, 16'h7777);
        data_req = 1'b1; data_we = 1'b1; data_byte_half = 1'b0;
        data_addr = 16'h0060; data_wdata = 16'h0011;
        tick();
        data_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_we_blocked", {ram_en, ram_we}, 2'b00);
        tick();
        check("rstmid_ram_kept", mem[15'h0030], 16'h7777);
        check("rstmid_no_ack", {fetch_ack, data_ack}, 2'b00);
        check("rstmid_busy", busy, 0);
        check("rstmid_rdata", {fetch_rdata, data_rdata}, 32'h0);
        check("rstmid_ram_addr", ram_addr, 0);
        reset = 1'b0;
        tick();

        // Held fetch request: no re-grant in the ack cycle.
        fetch_req = 1'b1; fetch_addr = 16'h0040;
        fa_vec = '0; busy_vec = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            fa_vec[c]   = fetch_ack;
            busy_vec[c] = busy;
        end
        fetch_req = 1'b0;
        check("hold_fetch_acks", fa_vec, 16'h0088);
        check("hold_busy", busy_vec, 16'h0666);
        tick();
        check("hold_last_ack", fetch_ack, 1);
        tick();
        check("hold_idle", {busy, fetch_ack}, 2'b00);

        // Vector table of data-port accesses.
        poke(15'h0010, 16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            xact(1'b0, vecs[i].we, vecs[i].half, vecs[i].addr, vecs[i].wdata, lat, rd);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
